// File: rtl/life_seq_ctrl.sv
// ---------------------------------------------------------------------------
// life_seq_ctrl
// Sequencer for a Game-of-Life PE array. One run clears the array, raster-
// loads a seed from a valid/ready stream, issues up to `gens` generation
// steps (stopping early if the board dies out), then streams the board out
// on a valid/ready stream.
//
// Ports
//   clk, reset                 clock, async active-high reset
//   start, gens                run request (IDLE only) and generation count
//   load_valid/ready/data      seed input stream, raster order (x fastest)
//   out_valid/ready/data/last  result output stream, same raster order
//   busy, done, gens_run       run status; done pulses once per run
//   cmd, state_in              registered array command and write data
//   adr_x_i, adr_y_i           registered array write address
//   adr_x_o, adr_y_o           registered array read address
//   array_state_out            addressed cell (combinational from adr_*_o)
//   array_active               high while any cell is alive
// ---------------------------------------------------------------------------
module life_seq_ctrl #(
    parameter int unsigned N_PX     = 16,
    parameter int unsigned N_PY     = 16,
    parameter int unsigned X_BITS   = 4,
    parameter int unsigned Y_BITS   = 4,
    parameter int unsigned CMD_BITS = 2,
    parameter logic [CMD_BITS-1:0] CMD_NOP   = CMD_BITS'(0),
    parameter logic [CMD_BITS-1:0] CMD_LOAD  = CMD_BITS'(1),
    parameter logic [CMD_BITS-1:0] CMD_STEP  = CMD_BITS'(2),
    parameter logic [CMD_BITS-1:0] CMD_CLEAR = CMD_BITS'(3),
    parameter int unsigned GEN_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [GEN_BITS-1:0] gens,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic                load_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic [GEN_BITS-1:0] gens_run,
    output logic [CMD_BITS-1:0] cmd,
    output logic                state_in,
    output logic [X_BITS-1:0]   adr_x_i,
    output logic [Y_BITS-1:0]   adr_y_i,
    output logic [X_BITS-1:0]   adr_x_o,
    output logic [Y_BITS-1:0]   adr_y_o,
    input  logic                array_state_out,
    input  logic                array_active
);

    localparam logic [X_BITS-1:0]   X_LAST  = X_BITS'(N_PX - 1);
    localparam logic [Y_BITS-1:0]   Y_LAST  = Y_BITS'(N_PY - 1);
    localparam logic [GEN_BITS-1:0] GEN_MAX = '1;
    // A 1x1 board has its first read address equal to its last one.
    localparam logic SINGLE_CELL = (X_LAST == '0) && (Y_LAST == '0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_STEP,
        S_WAIT,
        S_READ,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [CMD_BITS-1:0] cmd_q, cmd_d;
    logic                state_in_q, state_in_d;
    logic [X_BITS-1:0]   adr_xi_q, adr_xi_d;
    logic [Y_BITS-1:0]   adr_yi_q, adr_yi_d;
    logic [X_BITS-1:0]   adr_xo_q, adr_xo_d;
    logic [Y_BITS-1:0]   adr_yo_q, adr_yo_d;
    logic [X_BITS-1:0]   ld_x_q, ld_x_d;
    logic [Y_BITS-1:0]   ld_y_q, ld_y_d;
    logic                load_ready_q, load_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [GEN_BITS-1:0] gens_q, gens_d;
    logic [GEN_BITS-1:0] gens_run_q, gens_run_d;

    // Next-state and next-output logic; cmd and done default to idle values
    // so every command is a single-cycle event.
    always_comb begin
        state_d      = state_q;
        cmd_d        = CMD_NOP;
        state_in_d   = state_in_q;
        adr_xi_d     = adr_xi_q;
        adr_yi_d     = adr_yi_q;
        adr_xo_d     = adr_xo_q;
        adr_yo_d     = adr_yo_q;
        ld_x_d       = ld_x_q;
        ld_y_d       = ld_y_q;
        load_ready_d = load_ready_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;
        gens_d       = gens_q;
        gens_run_d   = gens_run_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    cmd_d      = CMD_CLEAR;
                    gens_d     = gens;
                    gens_run_d = '0;
                    ld_x_d     = '0;
                    ld_y_d     = '0;
                    adr_xo_d   = '0;
                    adr_yo_d   = '0;
                end
            end

            S_CLEAR: begin
                state_d      = S_LOAD;
                load_ready_d = 1'b1;
            end

            S_LOAD: begin
                if (load_valid && load_ready_q) begin
                    cmd_d      = CMD_LOAD;
                    state_in_d = load_data;
                    adr_xi_d   = ld_x_q;
                    adr_yi_d   = ld_y_q;
                    if (ld_x_q == X_LAST) begin
                        ld_x_d = '0;
                        if (ld_y_q == Y_LAST) begin
                            // Last seed beat: stop accepting on the same edge.
                            ld_y_d       = '0;
                            load_ready_d = 1'b0;
                            state_d      = S_STEP;
                        end else begin
                            ld_y_d = ld_y_q + Y_BITS'(1);
                        end
                    end else begin
                        ld_x_d = ld_x_q + X_BITS'(1);
                    end
                end
            end

            S_STEP: begin
                if ((gens_run_q == gens_q) || !array_active) begin
                    state_d     = S_READ;
                    out_valid_d = 1'b1;
                    adr_xo_d    = '0;
                    adr_yo_d    = '0;
                    out_last_d  = SINGLE_CELL;
                end else begin
                    state_d = S_WAIT;
                    cmd_d   = CMD_STEP;
                    if (gens_run_q != GEN_MAX) begin
                        gens_run_d = gens_run_q + GEN_BITS'(1);
                    end
                end
            end

            // One idle cycle lets the PEs settle before array_active is used.
            S_WAIT: begin
                state_d = S_STEP;
            end

            S_READ: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = S_FIN;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        if (adr_xo_q == X_LAST) begin
                            adr_xo_d = '0;
                            adr_yo_d = adr_yo_q + Y_BITS'(1);
                        end else begin
                            adr_xo_d = adr_xo_q + X_BITS'(1);
                        end
                        out_last_d = (adr_xo_d == X_LAST) && (adr_yo_d == Y_LAST);
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_q        <= CMD_NOP;
            state_in_q   <= 1'b0;
            adr_xi_q     <= '0;
            adr_yi_q     <= '0;
            adr_xo_q     <= '0;
            adr_yo_q     <= '0;
            ld_x_q       <= '0;
            ld_y_q       <= '0;
            load_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            gens_q       <= '0;
            gens_run_q   <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            state_in_q   <= state_in_d;
            adr_xi_q     <= adr_xi_d;
            adr_yi_q     <= adr_yi_d;
            adr_xo_q     <= adr_xo_d;
            adr_yo_q     <= adr_yo_d;
            ld_x_q       <= ld_x_d;
            ld_y_q       <= ld_y_d;
            load_ready_q <= load_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            gens_q       <= gens_d;
            gens_run_q   <= gens_run_d;
        end
    end

    assign cmd        = cmd_q;
    assign state_in   = state_in_q;
    assign adr_x_i    = adr_xi_q;
    assign adr_y_i    = adr_yi_q;
    assign adr_x_o    = adr_xo_q;
    assign adr_y_o    = adr_yo_q;
    assign load_ready = load_ready_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign gens_run   = gens_run_q;
    // Read data comes straight from the array at the registered read address.
    assign out_data   = array_state_out;

endmodule

// File: doc/life_seq_ctrl.md
# life_seq_ctrl

Sequencer that sits directly upstream of the PE array and drives its command, write-address and read-address ports. One run clears the array and raster-loads a seed pattern from a valid/ready input stream. It then issues a programmed number of generation steps, or stops early on extinction. Finally it streams the resulting board out on a valid/ready output stream toward the display/host side.

## Interface
Parameters:
- N_PX, 16, board width (columns)
- N_PY, 16, board height (rows)
- X_BITS, 4, column address width (≥ clog2(N_PX))
- Y_BITS, 4, row address width (≥ clog2(N_PY))
- CMD_BITS, 2, array command width
- CMD_NOP, 0, idle command code
- CMD_LOAD, 1, write state_in into addressed PE
- CMD_STEP, 2, advance every PE one generation
- CMD_CLEAR, 3, zero every PE
- GEN_BITS, 16, generation counter width

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; all registers to reset values immediately
- start  in  1  run request, sampled only in IDLE
- gens  in  GEN_BITS  generations to run, latched on accepted start
- load_valid  in  1  seed beat valid
- load_ready  out  1  seed beat accepted when load_valid & load_ready
- load_data  in  1  seed cell value, raster order (x fastest, then y)
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result beat
- out_data  out  1  result cell value, same raster order
- out_last  out  1  high on final beat (x=N_PX-1, y=N_PY-1)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of run
- gens_run  out  GEN_BITS  generations actually executed in last run
- cmd  out  CMD_BITS  array command, registered
- state_in  out  1  array write data, registered
- adr_x_i / adr_y_i  out  X_BITS / Y_BITS  array write address, registered
- adr_x_o / adr_y_o  out  X_BITS / Y_BITS  array read address, registered
- array_state_out  in  1  addressed cell value from array (combinational from adr_*_o)
- array_active  in  1  high while any cell is alive

## Operation
- States: IDLE → CLEAR → LOAD → STEP ⇄ WAIT → READ → FIN → IDLE.
- IDLE: cmd=NOP. When start=1, latch gens, zero gens_run and counters, go to CLEAR.
- CLEAR: one cycle with cmd=CLEAR, then LOAD.
- LOAD: load_ready=1. On each accepted beat, register cmd=LOAD, state_in=load_data, adr_x_i/adr_y_i=current raster position for exactly one cycle. Advance x, wrapping to 0 at N_PX-1 with y+1. Cycles without an accepted beat drive cmd=NOP. After beat N_PX*N_PY, load_ready drops in the same cycle the last beat is accepted; next state STEP.
- STEP: if the generation counter equals the latched gens, or array_active=0, go to READ; cmd stays NOP. Otherwise cmd=STEP for one cycle, increment gens_run, go to WAIT.
- WAIT: one cycle with cmd=NOP (PE settle), then back to STEP.
- gens=0: no STEP commands are issued; the board reads back equal to the seed.
- READ: adr_x_o/adr_y_o start at (0,0). out_valid=1 and out_data=array_state_out. On out_valid & out_ready, advance the raster with the same wrap rule. out_last is high on the final address; its acceptance moves to FIN.
- FIN: done=1 for one cycle, then IDLE. gens_run holds until the next accepted start.
- Counter widths: the raster counter is X_BITS+Y_BITS wide. The generation counter saturates at 2^GEN_BITS-1 and never wraps.

## Timing
- Reset values: cmd=CMD_NOP; state_in=0; all addresses 0; load_ready=0; out_valid=0; out_last=0; busy=0; done=0; gens_run=0; state IDLE.
- Accepted start → cmd=CLEAR on the next cycle → load_ready=1 the cycle after.
- Accepted load beat at edge k → cmd=LOAD visible during cycle k+1.
- Best-case load: N_PX*N_PY cycles.
- Each generation costs 2 cycles (STEP + WAIT).
- array_active is sampled in STEP, one cycle after the previous STEP command completes.
- out_data is combinational from the registered read address.
- While out_ready=0, out_valid, out_data, out_last and the address hold stable.
- Load back-pressure: load_valid low stalls LOAD indefinitely with cmd=NOP.
- start while busy: ignored.
- Reset mid-run: state returns to IDLE at once and the partial board is not cleared. The next run's CLEAR handles it.

## Test plan
- Blinker (cells (1,2),(2,2),(3,2)), gens=1 → output is the vertical blinker (2,1),(2,2),(2,3); gens_run=1; done pulses once after beat 256 with out_last on that beat.
- Glider seed, gens=4 → pattern shifted (+1,+1); exactly 4 STEP commands, each followed by a NOP cycle.
- gens=0, random seed → output equals the seed bit-for-bit; no STEP ever issued.
- Single cell, gens=100 → extinct after one step; gens_run=1; all 256 output beats 0.
- Random load_valid/out_ready throttling (50%) → same results as full throughput; out_data stable while stalled; no beat lost or duplicated.
- Assert reset mid-LOAD and mid-READ → all outputs at reset values the same cycle. A fresh run then produces a correct board; start pulses while busy are ignored.
